// File: rtl/stateless_alu_arbiter.sv
// rtl/stateless_alu_arbiter.sv - round-robin front end sharing one stateless ALU among NUM_REQ requesters
module stateless_alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             i__req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i__req_pkt_1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i__req_pkt_2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i__req_pkt_3,

    input  logic                           i__cfg_we,
    input  logic [ID_WIDTH-1:0]            i__cfg_id,
    input  logic                           i__cfg_en,
    input  logic [3:0]                     i__cfg_opcode,
    input  logic [9:0]                     i__cfg_sel,
    input  logic [DATA_WIDTH-1:0]          i__cfg_cons,

    output logic [DATA_WIDTH-1:0]          o_alu_pkt_1,
    output logic [DATA_WIDTH-1:0]          o_alu_pkt_2,
    output logic [DATA_WIDTH-1:0]          o_alu_pkt_3,
    output logic [DATA_WIDTH-1:0]          o_alu_cons_1,
    output logic [3:0]                     o_alu_opcode,
    output logic [1:0]                     o_alu_sel_1,
    output logic [1:0]                     o_alu_sel_2,
    output logic [1:0]                     o_alu_sel_3,
    output logic [1:0]                     o_alu_sel_4,
    output logic [1:0]                     o_alu_sel_5,
    input  logic [DATA_WIDTH-1:0]          i__alu_result,

    output logic                           o_resp_valid,
    output logic [ID_WIDTH-1:0]            o_resp_id,
    output logic [DATA_WIDTH-1:0]          o_resp_data
);

    logic [NUM_REQ-1:0]    r_cfg_en;
    logic [3:0]            r_cfg_opcode [NUM_REQ];
    logic [9:0]            r_cfg_sel    [NUM_REQ];
    logic [DATA_WIDTH-1:0] r_cfg_cons   [NUM_REQ];

    logic [ID_WIDTH-1:0]   r_rr_ptr;

    logic                  r_tag1_valid;
    logic [ID_WIDTH-1:0]   r_tag1_id;
    logic                  r_tag2_valid;
    logic [ID_WIDTH-1:0]   r_tag2_id;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic                  w_gnt_valid;
    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic [ID_WIDTH-1:0]   w_ptr_next;

    logic [DATA_WIDTH-1:0] w_alu_pkt_1;
    logic [DATA_WIDTH-1:0] w_alu_pkt_2;
    logic [DATA_WIDTH-1:0] w_alu_pkt_3;
    logic [DATA_WIDTH-1:0] w_alu_cons;
    logic [3:0]            w_alu_opcode;
    logic [9:0]            w_alu_sel;

    assign w_elig = i__req_valid & r_cfg_en;

    // Two passes give the wrapping search: first ids at/above the pointer, then those below it.
    always_comb begin
        w_gnt_oh    = '0;
        w_gnt_valid = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_valid && w_elig[k] && (ID_WIDTH'(k) >= r_rr_ptr)) begin
                w_gnt_oh[k] = 1'b1;
                w_gnt_valid = 1'b1;
                w_gnt_id    = ID_WIDTH'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_valid && w_elig[k] && (ID_WIDTH'(k) < r_rr_ptr)) begin
                w_gnt_oh[k] = 1'b1;
                w_gnt_valid = 1'b1;
                w_gnt_id    = ID_WIDTH'(k);
            end
        end
    end

    always_comb begin
        w_ptr_next = r_rr_ptr;
        if (w_gnt_valid) begin
            if (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_gnt_id + ID_WIDTH'(1);
            end
        end
    end

    assign o_req_ready = w_gnt_oh;

    // Idle cycles present all-zero operands so the ALU sees a harmless add.
    always_comb begin
        w_alu_pkt_1  = '0;
        w_alu_pkt_2  = '0;
        w_alu_pkt_3  = '0;
        w_alu_cons   = '0;
        w_alu_opcode = '0;
        w_alu_sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_oh[k]) begin
                w_alu_pkt_1  = i__req_pkt_1[k*DATA_WIDTH +: DATA_WIDTH];
                w_alu_pkt_2  = i__req_pkt_2[k*DATA_WIDTH +: DATA_WIDTH];
                w_alu_pkt_3  = i__req_pkt_3[k*DATA_WIDTH +: DATA_WIDTH];
                w_alu_cons   = r_cfg_cons[k];
                w_alu_opcode = r_cfg_opcode[k];
                w_alu_sel    = r_cfg_sel[k];
            end
        end
    end

    assign o_alu_pkt_1  = w_alu_pkt_1;
    assign o_alu_pkt_2  = w_alu_pkt_2;
    assign o_alu_pkt_3  = w_alu_pkt_3;
    assign o_alu_cons_1 = w_alu_cons;
    assign o_alu_opcode = w_alu_opcode;
    assign o_alu_sel_1  = w_alu_sel[1:0];
    assign o_alu_sel_2  = w_alu_sel[3:2];
    assign o_alu_sel_3  = w_alu_sel[5:4];
    assign o_alu_sel_4  = w_alu_sel[7:6];
    assign o_alu_sel_5  = w_alu_sel[9:8];

    // Table reads in the steering path see the pre-write entry, so a same-cycle write lands next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_en <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_cfg_opcode[k] <= '0;
                r_cfg_sel[k]    <= '0;
                r_cfg_cons[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i__cfg_we && (i__cfg_id == ID_WIDTH'(k))) begin
                    r_cfg_en[k]     <= i__cfg_en;
                    r_cfg_opcode[k] <= i__cfg_opcode;
                    r_cfg_sel[k]    <= i__cfg_sel;
                    r_cfg_cons[k]   <= i__cfg_cons;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Stage 1 tracks the op inside the ALU; stage 2 is captured alongside its result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag1_valid <= 1'b0;
            r_tag1_id    <= '0;
            r_tag2_valid <= 1'b0;
            r_tag2_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            r_tag1_valid <= w_gnt_valid;
            r_tag1_id    <= w_gnt_id;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_id    <= r_tag1_id;
            if (r_tag1_valid) begin
                r_resp_data <= i__alu_result;
            end
        end
    end

    assign o_resp_valid = r_tag2_valid;
    assign o_resp_id    = r_tag2_id;
    assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_stateless_alu_arbiter.sv
// tb/tb_stateless_alu_arbiter.sv - directed bench for stateless_alu_arbiter with a behavioural ALU
module tb_stateless_alu_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 32;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] pkt_1;
    logic [NUM_REQ*DATA_WIDTH-1:0] pkt_2;
    logic [NUM_REQ*DATA_WIDTH-1:0] pkt_3;
    logic                          cfg_we;
    logic [ID_WIDTH-1:0]           cfg_id;
    logic                          cfg_en;
    logic [3:0]                    cfg_opcode;
    logic [9:0]                    cfg_sel;
    logic [DATA_WIDTH-1:0]         cfg_cons;
    logic [DATA_WIDTH-1:0]         alu_pkt_1, alu_pkt_2, alu_pkt_3, alu_cons;
    logic [3:0]                    alu_opcode;
    logic [1:0]                    alu_sel_1, alu_sel_2, alu_sel_3, alu_sel_4, alu_sel_5;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          resp_valid;
    logic [ID_WIDTH-1:0]           resp_id;
    logic [DATA_WIDTH-1:0]         resp_data;

    int checks   = 0;
    int failures = 0;

    stateless_alu_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i__req_valid(req_valid), .o_req_ready(req_ready),
        .i__req_pkt_1(pkt_1), .i__req_pkt_2(pkt_2), .i__req_pkt_3(pkt_3),
        .i__cfg_we(cfg_we), .i__cfg_id(cfg_id), .i__cfg_en(cfg_en),
        .i__cfg_opcode(cfg_opcode), .i__cfg_sel(cfg_sel), .i__cfg_cons(cfg_cons),
        .o_alu_pkt_1(alu_pkt_1), .o_alu_pkt_2(alu_pkt_2), .o_alu_pkt_3(alu_pkt_3),
        .o_alu_cons_1(alu_cons), .o_alu_opcode(alu_opcode),
        .o_alu_sel_1(alu_sel_1), .o_alu_sel_2(alu_sel_2), .o_alu_sel_3(alu_sel_3),
        .o_alu_sel_4(alu_sel_4), .o_alu_sel_5(alu_sel_5),
        .i__alu_result(alu_result),
        .o_resp_valid(resp_valid), .o_resp_id(resp_id), .o_resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: captures operands at the edge, result valid throughout the following cycle.
    logic [DATA_WIDTH-1:0] m_p1, m_p2, m_cons;
    logic [3:0]            m_op;
    logic [1:0]            m_s1, m_s2, m_s3, m_s4, m_s5;

    always @(posedge clk) begin
        m_p1 <= alu_pkt_1; m_p2 <= alu_pkt_2; m_cons <= alu_cons; m_op <= alu_opcode;
        m_s1 <= alu_sel_1; m_s2 <= alu_sel_2; m_s3 <= alu_sel_3; m_s4 <= alu_sel_4; m_s5 <= alu_sel_5;
    end

    function automatic logic [DATA_WIDTH-1:0] operand(input logic [1:0] s);
        case (s)
            2'd0:    return m_p1;
            2'd1:    return m_p2;
            default: return m_cons;
        endcase
    endfunction

    always_comb begin
        case (m_op)
            4'd0:    alu_result = operand(m_s1) + operand(m_s2);
            4'd1:    alu_result = operand(m_s1) - operand(m_s2);
            4'd11:   alu_result = (operand(m_s3) != 0) ? operand(m_s4) : operand(m_s5);
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int id, input logic en, input logic [3:0] op,
                             input logic [9:0] sel, input logic [DATA_WIDTH-1:0] cons);
        cfg_we = 1'b1; cfg_id = ID_WIDTH'(id); cfg_en = en;
        cfg_opcode = op; cfg_sel = sel; cfg_cons = cons;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; pkt_1 = '0; pkt_2 = '0; pkt_3 = '0;
        cfg_we = 1'b0; cfg_id = '0; cfg_en = 1'b0; cfg_opcode = '0; cfg_sel = '0; cfg_cons = '0;
        tick(); tick();

        req_valid = 4'b1111;
        pkt_1 = {4{32'hDEAD_BEEF}};
        #4;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_id", 64'(resp_id), 64'h0);
        chk("rst_resp_data", 64'(resp_data), 64'h0);
        chk("rst_alu_pkt_1", 64'(alu_pkt_1), 64'h0);
        tick();
        rst_n = 1'b1; req_valid = '0; pkt_1 = '0;

        // Single add: 10 + cons 5
        cfg_write(0, 1'b1, 4'd0, 10'h008, 32'd5);
        pkt_1[0 +: 32] = 32'd10;
        pkt_3[0 +: 32] = 32'h33;
        req_valid = 4'b0001;
        #4;
        chk("add_ready", 64'(req_ready), 64'h1);
        chk("add_alu_pkt_1", 64'(alu_pkt_1), 64'd10);
        chk("add_alu_pkt_3", 64'(alu_pkt_3), 64'h33);
        chk("add_alu_cons", 64'(alu_cons), 64'd5);
        chk("add_alu_sel_2", 64'(alu_sel_2), 64'd2);
        chk("add_no_early_resp", 64'(resp_valid), 64'h0);
        tick();
        req_valid = '0;
        #4;
        chk("add_t1_resp_valid", 64'(resp_valid), 64'h0);
        tick();
        #4;
        chk("add_t2_resp_valid", 64'(resp_valid), 64'h1);
        chk("add_t2_resp_id", 64'(resp_id), 64'h0);
        chk("add_t2_resp_data", 64'(resp_data), 64'd15);
        tick();
        #4;
        chk("add_t3_resp_valid", 64'(resp_valid), 64'h0);
        chk("add_t3_data_hold", 64'(resp_data), 64'd15);
        tick();

        // Round-robin fairness from a freshly reset pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            cfg_write(k, 1'b1, 4'd0, 10'h004, 32'd0);
            pkt_1[k*32 +: 32] = 32'(100 + k);
            pkt_2[k*32 +: 32] = 32'd0;
        end
        for (int j = 0; j < 9; j++) begin
            req_valid = (j < 6) ? 4'b1111 : 4'b0000;
            #4;
            if (j < 6) chk($sformatf("rr_ready_%0d", j), 64'(req_ready), 64'(4'b0001 << (j % 4)));
            else       chk($sformatf("rr_ready_%0d", j), 64'(req_ready), 64'h0);
            if (j >= 2 && j < 8) begin
                chk($sformatf("rr_resp_valid_%0d", j), 64'(resp_valid), 64'h1);
                chk($sformatf("rr_resp_id_%0d", j), 64'(resp_id), 64'((j - 2) % 4));
                chk($sformatf("rr_resp_data_%0d", j), 64'(resp_data), 64'(100 + (j - 2) % 4));
            end else begin
                chk($sformatf("rr_resp_valid_%0d", j), 64'(resp_valid), 64'h0);
            end
            tick();
        end

        // Disabled requester never wins
        cfg_write(2, 1'b0, 4'd5, 10'h004, 32'd0);
        req_valid = 4'b0100;
        for (int j = 0; j < 20; j++) begin
            #4;
            chk($sformatf("dis_ready_%0d", j), 64'(req_ready), 64'h0);
            chk($sformatf("dis_resp_valid_%0d", j), 64'(resp_valid), 64'h0);
            chk($sformatf("dis_opcode_%0d", j), 64'(alu_opcode), 64'h0);
            chk($sformatf("dis_pkt_1_%0d", j), 64'(alu_pkt_1), 64'h0);
            tick();
        end
        req_valid = '0;

        // Config write in the same cycle as a grant: old entry used, new one next grant
        pkt_1[1*32 +: 32] = 32'd8;
        pkt_2[1*32 +: 32] = 32'd3;
        req_valid = 4'b0010;
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_en = 1'b1; cfg_opcode = 4'd1; cfg_sel = 10'h004; cfg_cons = '0;
        #4;
        chk("haz_ready_0", 64'(req_ready), 64'h2);
        chk("haz_opcode_old", 64'(alu_opcode), 64'd0);
        tick();
        cfg_we = 1'b0;
        #4;
        chk("haz_ready_1", 64'(req_ready), 64'h2);
        chk("haz_opcode_new", 64'(alu_opcode), 64'd1);
        tick();
        req_valid = '0;
        #4;
        chk("haz_resp0_valid", 64'(resp_valid), 64'h1);
        chk("haz_resp0_id", 64'(resp_id), 64'h1);
        chk("haz_resp0_data", 64'(resp_data), 64'd11);
        tick();
        #4;
        chk("haz_resp1_valid", 64'(resp_valid), 64'h1);
        chk("haz_resp1_data", 64'(resp_data), 64'd5);
        tick();
        #4;
        chk("haz_idle", 64'(resp_valid), 64'h0);
        tick();

        // Conditional select: pkt_1 ? pkt_2 : cons
        cfg_write(3, 1'b1, 4'd11, 10'h340, 32'd7);
        pkt_1[3*32 +: 32] = 32'd0;
        pkt_2[3*32 +: 32] = 32'd9;
        req_valid = 4'b1000;
        #4;
        chk("cond_ready_0", 64'(req_ready), 64'h8);
        chk("cond_sel_5", 64'(alu_sel_5), 64'd3);
        chk("cond_sel_4", 64'(alu_sel_4), 64'd1);
        tick();
        pkt_1[3*32 +: 32] = 32'd1;
        #4;
        chk("cond_ready_1", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        #4;
        chk("cond_resp0_id", 64'(resp_id), 64'h3);
        chk("cond_resp0_data", 64'(resp_data), 64'd7);
        tick();
        #4;
        chk("cond_resp1_valid", 64'(resp_valid), 64'h1);
        chk("cond_resp1_data", 64'(resp_data), 64'd9);
        tick();
        #4;
        tick();

        // Reset while two grants are in flight
        req_valid = 4'b0001;
        #4;
        chk("rmf_ready_t0", 64'(req_ready), 64'h1);
        tick();
        rst_n = 1'b0;
        #4;
        chk("rmf_ready_t1", 64'(req_ready), 64'h1);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int j = 0; j < 3; j++) begin
            #4;
            chk($sformatf("rmf_no_resp_%0d", j), 64'(resp_valid), 64'h0);
            chk($sformatf("rmf_tbl_cleared_%0d", j), 64'(req_ready), 64'h0);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cfg_write(k, 1'b1, 4'd0, 10'h004, 32'd0);
        end
        req_valid = 4'b1111;
        #4;
        chk("rmf_ptr_first", 64'(req_ready), 64'h1);
        tick();
        #4;
        chk("rmf_ptr_second", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
